// File: rtl/sb_tx_serializer.sv
// sb_tx_serializer: edge-triggered sideband frame serializer (start, MSB-first data, even parity, stop, gap) with one-entry pending slot
module sb_tx_serializer #(
  parameter int SB_MSG_WIDTH = 4,
  parameter int BIT_CYCLES = 2,
  parameter int GAP_CYCLES = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_tx_msg_valid,
  input  logic [SB_MSG_WIDTH-1:0] i_TX_SbMessage,
  output logic                    o_sb_data,
  output logic                    o_busy,
  output logic                    o_falling_edge_busy,
  output logic                    o_overflow
);
  localparam int BW = SB_MSG_WIDTH > 1 ? $clog2(SB_MSG_WIDTH) : 1;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, GAP} state_t;
  state_t state, state_n;
  logic prev_valid, req, pend_full, parity, cyc_done, last_bit;
  logic [SB_MSG_WIDTH-1:0] shreg, pend_msg, load_msg;
  logic [3:0] cyc;
  logic [BW-1:0] bitc;
  assign req = i_tx_msg_valid & ~prev_valid;
  assign cyc_done = cyc == 4'd0;
  assign last_bit = bitc == '0;
  assign load_msg = pend_full ? pend_msg : i_TX_SbMessage;
  always_comb begin
    state_n = state;
    o_busy = state != IDLE;
    o_sb_data = state == START || (state == DATA && shreg[SB_MSG_WIDTH-1]) || (state == PARITY && parity);
    case (state)
      IDLE:    state_n = req || pend_full ? START : IDLE;
      START:   state_n = cyc_done ? DATA : START;
      DATA:    state_n = cyc_done && last_bit ? PARITY : DATA;
      PARITY:  state_n = cyc_done ? STOP : PARITY;
      STOP:    state_n = cyc_done ? GAP : STOP;
      GAP:     state_n = cyc_done ? IDLE : GAP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      prev_valid <= 1'b0;
      pend_full <= 1'b0;
      pend_msg <= '0;
      shreg <= '0;
      parity <= 1'b0;
      cyc <= 4'd0;
      bitc <= '0;
      o_falling_edge_busy <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      state <= state_n;
      prev_valid <= i_tx_msg_valid;
      o_falling_edge_busy <= state == GAP && state_n == IDLE;
      o_overflow <= 1'b0;
      if (state_n != state) begin
        cyc <= state_n == GAP ? 4'(GAP_CYCLES - 1) : state_n == IDLE ? 4'd0 : 4'(BIT_CYCLES - 1);
        bitc <= state_n == DATA ? BW'(SB_MSG_WIDTH - 1) : '0;
      end else if (state == DATA && cyc_done) begin
        cyc <= 4'(BIT_CYCLES - 1);
        bitc <= bitc - 1'b1;
      end else if (!cyc_done) begin
        cyc <= cyc - 4'd1;
      end
      if (state == IDLE && state_n == START) begin
        shreg <= load_msg;
        parity <= ^load_msg;
      end else if (state == DATA && cyc_done) begin
        shreg <= shreg << 1;
      end
      // a pending frame drains in IDLE; a request in that same cycle refills the slot
      if (state == IDLE && pend_full) pend_full <= 1'b0;
      if (req && (state != IDLE || pend_full)) begin
        if (pend_full && state != IDLE) begin
          o_overflow <= 1'b1;
        end else begin
          pend_msg <= i_TX_SbMessage;
          pend_full <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_sb_tx_serializer.sv
// tb_sb_tx_serializer: directed scoreboard bench for sb_tx_serializer with default parameters
module tb_sb_tx_serializer;
  logic clk = 1'b0;
  logic rst, valid;
  logic [3:0] msg;
  logic sb_data, busy, fall, ovf;
  int checks = 0, errors = 0;
  int frames = 0, falls = 0, ovfs = 0, n = 0, idle_run = 0, last_gap = 0;
  logic [15:0] cap;
  logic [15:0] exp_q[$];
  logic [15:0] exp_line;
  int f0, fr0, o0;

  sb_tx_serializer #(.SB_MSG_WIDTH(4), .BIT_CYCLES(2), .GAP_CYCLES(2)) dut (
    .i_clk(clk), .i_rst(rst), .i_tx_msg_valid(valid), .i_TX_SbMessage(msg),
    .o_sb_data(sb_data), .o_busy(busy), .o_falling_edge_busy(fall), .o_overflow(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  // line bit j is o_sb_data in the j-th busy cycle of a frame
  function automatic logic [15:0] frame_of(input logic [3:0] m);
    logic [6:0] b;
    logic [15:0] f;
    b = {1'b1, m, ^m, 1'b0};
    f = '0;
    for (int j = 0; j < 14; j++) f[j] = b[6 - j/2];
    return f;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      n = 0;
    end else if (busy) begin
      if (n == 0) begin
        last_gap = idle_run;
        idle_run = 0;
      end
      if (n < 16) cap[n] = sb_data;
      n++;
    end else begin
      idle_run++;
      if (n > 0) begin
        frames++;
        chk("frame_len", n, 16);
        chk("fall_at_first_idle", fall, 1);
        chk("frame_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          exp_line = exp_q.pop_front();
          chk("frame_bits", cap, exp_line);
        end
        n = 0;
      end
    end
    if (fall) falls++;
    if (ovf) ovfs++;
  end

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [3:0] m);
    valid = 1'b1;
    msg = m;
    tick(1);
    valid = 1'b0;
    tick(1);
  endtask

  task automatic wait_idle(input int bound);
    int i;
    for (i = 0; i < bound; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) break;
    end
    chk("wait_timeout", i < bound, 1);
    tick(3);
  endtask

  task automatic snap();
    f0 = falls;
    fr0 = frames;
    o0 = ovfs;
  endtask

  initial begin
    rst = 1'b1;
    valid = 1'b0;
    msg = 4'h0;
    tick(3);
    @(negedge clk);
    chk("rst_sb_data", sb_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fall", fall, 0);
    chk("rst_ovf", ovf, 0);
    tick(1);
    rst = 1'b0;
    tick(2);

    // single ENTRY_REQ frame, with first-cycle latency check
    snap();
    exp_q.push_back(frame_of(4'hF));
    valid = 1'b1;
    msg = 4'hF;
    @(posedge clk);
    @(negedge clk);
    chk("lat_busy", busy, 1);
    chk("lat_sb_data", sb_data, 1);
    valid = 1'b0;
    msg = 4'h0;
    wait_idle(40);
    chk("f_falls", falls - f0, 1);
    chk("f_frames", frames - fr0, 1);

    // ENTRY_RESP, message changed after capture
    snap();
    exp_q.push_back(frame_of(4'hE));
    valid = 1'b1;
    msg = 4'hE;
    @(posedge clk);
    @(negedge clk);
    chk("lat_busy_e", busy, 1);
    valid = 1'b0;
    msg = 4'h3;
    wait_idle(40);
    chk("e_frames", frames - fr0, 1);

    // level held high must not retrigger
    snap();
    exp_q.push_back(frame_of(4'h5));
    valid = 1'b1;
    msg = 4'h5;
    tick(40);
    valid = 1'b0;
    wait_idle(40);
    chk("hold_frames", frames - fr0, 1);
    chk("hold_falls", falls - f0, 1);

    // second edge mid-frame goes to the pending slot
    snap();
    exp_q.push_back(frame_of(4'hF));
    pulse(4'hF);
    tick(4);
    exp_q.push_back(frame_of(4'hE));
    pulse(4'hE);
    wait_idle(80);
    chk("pend_frames", frames - fr0, 2);
    chk("pend_falls", falls - f0, 2);
    chk("pend_gap", last_gap, 1);
    chk("pend_ovf", ovfs - o0, 0);

    // third edge in one frame overflows
    snap();
    exp_q.push_back(frame_of(4'h9));
    pulse(4'h9);
    exp_q.push_back(frame_of(4'h6));
    pulse(4'h6);
    pulse(4'hA);
    wait_idle(80);
    chk("ovf_pulses", ovfs - o0, 1);
    chk("ovf_frames", frames - fr0, 2);

    // reset during DATA with a pending request
    snap();
    pulse(4'hF);
    pulse(4'hE);
    tick(1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_sb_data", sb_data, 0);
    tick(1);
    rst = 1'b0;
    tick(30);
    chk("abort_frames", frames - fr0, 0);
    chk("abort_falls", falls - f0, 0);

    // fresh edge after release
    snap();
    exp_q.push_back(frame_of(4'hC));
    pulse(4'hC);
    wait_idle(40);
    chk("fresh_frames", frames - fr0, 1);
    chk("fresh_falls", falls - f0, 1);

    // valid held across reset release counts as an edge
    snap();
    rst = 1'b1;
    valid = 1'b1;
    msg = 4'h7;
    tick(2);
    exp_q.push_back(frame_of(4'h7));
    rst = 1'b0;
    wait_idle(40);
    valid = 1'b0;
    chk("held_rst_frames", frames - fr0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
